// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot controller.
//
// Holds the per-gate passage FSM state encoding and the sensor-pair
// codes {SA,SB} used by both the gate FSM and the top level.
package parking_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_IN1  = 3'd1,
    ST_IN2  = 3'd2,
    ST_IN3  = 3'd3,
    ST_OUT1 = 3'd4,
    ST_OUT2 = 3'd5,
    ST_OUT3 = 3'd6
  } gate_state_t;

  // Sensor pair codes, written as {SA,SB}; SA is the outer beam.
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;

endpackage

// File: rtl/parking_gate_fsm.sv
// Passage detector for one bidirectional gate.
//
// Tracks a vehicle crossing the outer (SA) and inner (SB) beams. A full
// outer->inner sequence produces a one-cycle ENTER pulse, and a full
// inner->outer sequence produces a one-cycle EXIT pulse. Any sensor
// pattern that does not fit a passage returns the FSM to IDLE silently.
//
// Ports:
//   CLK     : rising-edge clock
//   RESET_N : asynchronous active-low reset
//   SA, SB  : outer / inner beam, 1 = blocked
//   ENTER   : registered one-cycle pulse on completed entry
//   EXIT    : registered one-cycle pulse on completed exit
//   S       : current state (parking_pkg encoding)
module parking_gate_fsm
  import parking_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               SA,
  input  logic               SB,
  output logic               ENTER,
  output logic               EXIT,
  output logic [STATE_W-1:0] S
);

  gate_state_t state;
  logic [1:0]  ab;

  assign ab = {SA, SB};
  assign S  = state;

  // Each state has exactly one "holding" sensor code, the one that led
  // into it, so no copy of the previous input is needed to detect a
  // change.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      ENTER <= 1'b0;
      EXIT  <= 1'b0;
    end else begin
      ENTER <= 1'b0;
      EXIT  <= 1'b0;
      case (state)
        ST_IDLE: begin
          case (ab)
            AB_10:   state <= ST_IN1;
            AB_01:   state <= ST_OUT1;
            default: state <= ST_IDLE;
          endcase
        end
        ST_IN1: begin
          case (ab)
            AB_10:   state <= ST_IN1;
            AB_11:   state <= ST_IN2;
            default: state <= ST_IDLE;
          endcase
        end
        ST_IN2: begin
          case (ab)
            AB_11:   state <= ST_IN2;
            AB_01:   state <= ST_IN3;
            AB_10:   state <= ST_IN1;
            default: state <= ST_IDLE;
          endcase
        end
        ST_IN3: begin
          case (ab)
            AB_01:   state <= ST_IN3;
            AB_11:   state <= ST_IN2;
            AB_00: begin
              state <= ST_IDLE;
              ENTER <= 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_OUT1: begin
          case (ab)
            AB_01:   state <= ST_OUT1;
            AB_11:   state <= ST_OUT2;
            default: state <= ST_IDLE;
          endcase
        end
        ST_OUT2: begin
          case (ab)
            AB_11:   state <= ST_OUT2;
            AB_10:   state <= ST_OUT3;
            AB_01:   state <= ST_OUT1;
            default: state <= ST_IDLE;
          endcase
        end
        ST_OUT3: begin
          case (ab)
            AB_10:   state <= ST_OUT3;
            AB_11:   state <= ST_OUT2;
            AB_00: begin
              state <= ST_IDLE;
              EXIT  <= 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking lot occupancy controller.
//
// One passage FSM per gate feeds a saturating occupancy counter. Entries
// and exits occurring in the same cycle are netted before saturation, so
// they cancel. Lost entries/exits set sticky OVF/UNF flags.
//
// Ports:
//   CLK, RESET_N : clock and asynchronous active-low reset
//   SA, SB       : per-gate outer / inner beam sensors, 1 = blocked
//   CLR_ERR      : clears OVF/UNF (a simultaneous new event wins)
//   ENTER, EXIT  : per-gate one-cycle passage pulses
//   COUNT        : occupied spaces, 0..CAPACITY
//   FULL, EMPTY  : COUNT==CAPACITY / COUNT==0
//   OVF, UNF     : sticky saturation flags
//   S            : per-gate FSM state, gate g at [3g+2:3g]
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int GATES    = 2,
  parameter int CAPACITY = 8,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [GATES-1:0]         SA,
  input  logic [GATES-1:0]         SB,
  input  logic                     CLR_ERR,
  output logic [GATES-1:0]         ENTER,
  output logic [GATES-1:0]         EXIT,
  output logic [CNT_W-1:0]         COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVF,
  output logic                     UNF,
  output logic [STATE_W*GATES-1:0] S
);

  // Two extra bits: one for the sign, one so COUNT+net can exceed
  // CAPACITY without wrapping.
  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  function automatic logic signed [SUM_W-1:0] popcount(input logic [GATES-1:0] v);
    logic signed [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < GATES; i++) begin
      acc = acc + $signed({{(SUM_W-1){1'b0}}, v[i]});
    end
    return acc;
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1]) begin
      return '0;
    end else if (v > CAP_S) begin
      return CNT_W'(CAPACITY);
    end else begin
      return v[CNT_W-1:0];
    end
  endfunction

  // ---- stage p0: per-gate passage detection (registered pulses) ----
  for (genvar g = 0; g < GATES; g++) begin : g_gate
    parking_gate_fsm u_gate (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .SA      (SA[g]),
      .SB      (SB[g]),
      .ENTER   (ENTER[g]),
      .EXIT    (EXIT[g]),
      .S       (S[STATE_W*g +: STATE_W])
    );
  end

  logic signed [SUM_W-1:0] net_p0;
  logic signed [SUM_W-1:0] sum_p0;
  logic                    ovf_evt_p0;
  logic                    unf_evt_p0;

  assign net_p0     = popcount(ENTER) - popcount(EXIT);
  assign sum_p0     = $signed({2'b00, COUNT}) + net_p0;
  assign ovf_evt_p0 = (sum_p0 > CAP_S);
  assign unf_evt_p0 = sum_p0[SUM_W-1];

  // ---- stage p1: saturating occupancy counter and sticky flags ----
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
    end else begin
      COUNT <= sat_count(sum_p0);
      OVF   <= ovf_evt_p0 | (OVF & ~CLR_ERR);
      UNF   <= unf_evt_p0 | (UNF & ~CLR_ERR);
    end
  end

  assign FULL  = (COUNT == CNT_W'(CAPACITY));
  assign EMPTY = (COUNT == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl (GATES=2, CAPACITY=8).
module tb_parking_lot_ctrl;

  localparam int GATES    = 2;
  localparam int CAPACITY = 8;
  localparam int CNT_W    = $clog2(CAPACITY + 1);

  logic               clk;
  logic               rst_n;
  logic [GATES-1:0]   sa;
  logic [GATES-1:0]   sb;
  logic               clr;
  logic [GATES-1:0]   ent;
  logic [GATES-1:0]   ext;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               ovf;
  logic               unf;
  logic [3*GATES-1:0] s;

  parking_lot_ctrl #(.GATES(GATES), .CAPACITY(CAPACITY)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .SA      (sa),
    .SB      (sb),
    .CLR_ERR (clr),
    .ENTER   (ent),
    .EXIT    (ext),
    .COUNT   (count),
    .FULL    (full),
    .EMPTY   (empty),
    .OVF     (ovf),
    .UNF     (unf),
    .S       (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic [1:0] ex;
    int         cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] en, input logic [1:0] ex, input int cnt,
                      input logic o, input logic u);
    exp_t e;
    e.en = en; e.ex = ex; e.cnt = cnt; e.ovf = o; e.unf = u;
    q.push_back(e);
  endtask

  // Monitor: whenever a pulse appears, pop the expected event, check the
  // pulse vectors, then check the counter/flags one edge later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ent != '0 || ext != '0) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: enter=%b exit=%b with nothing expected at %0t",
                   ent, ext, $time);
        end else begin
          e = q.pop_front();
          chk("sb_enter", int'(ent), int'(e.en));
          chk("sb_exit", int'(ext), int'(e.ex));
          @(negedge clk);
          chk("sb_count", int'(count), e.cnt);
          chk("sb_ovf", int'(ovf), int'(e.ovf));
          chk("sb_unf", int'(unf), int'(e.unf));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input logic [1:0] ab);
    sa[g] = ab[1];
    sb[g] = ab[0];
    tick();
  endtask

  task automatic drive2(input logic [1:0] ab0, input logic [1:0] ab1);
    sa = {ab1[1], ab0[1]};
    sb = {ab1[0], ab0[0]};
    tick();
  endtask

  task automatic entry(input int g);
    drive(g, 2'b10); drive(g, 2'b11); drive(g, 2'b01); drive(g, 2'b00);
  endtask

  task automatic exit_pass(input int g);
    drive(g, 2'b01); drive(g, 2'b11); drive(g, 2'b10); drive(g, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    sa    = '0;
    sb    = '0;
    clr   = 1'b0;

    // Reset state
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_pulses", int'({ent, ext}), 0);
    #18 rst_n = 1'b1;
    tick();
    chk("rel_count", int'(count), 0);
    chk("rel_empty", int'(empty), 1);
    chk("rel_s", int'(s), 0);

    // Entry at gate 0 with state trace
    drive(0, 2'b10); chk("entry_s0_in1", int'(s[2:0]), 1);
    drive(0, 2'b11); chk("entry_s0_in2", int'(s[2:0]), 2);
    drive(0, 2'b01); chk("entry_s0_in3", int'(s[2:0]), 3);
    push(2'b01, 2'b00, 1, 1'b0, 1'b0);
    drive(0, 2'b00); chk("entry_s0_idle", int'(s[2:0]), 0);
    chk("entry_pulse", int'(ent), 1);
    tick();
    chk("entry_pulse_gone", int'(ent), 0);
    tick();
    chk("entry_count", int'(count), 1);
    chk("entry_not_empty", int'(empty), 0);

    // Backtrack then abort at gate 1
    drive(1, 2'b10); chk("bt_s1_in1", int'(s[5:3]), 1);
    drive(1, 2'b11); chk("bt_s1_in2", int'(s[5:3]), 2);
    drive(1, 2'b10); chk("bt_s1_back", int'(s[5:3]), 1);
    drive(1, 2'b00); chk("bt_s1_idle", int'(s[5:3]), 0);
    tick(); tick();
    chk("bt_count", int'(count), 1);

    // Fill to capacity
    for (int i = 2; i <= CAPACITY; i++) begin
      push(2'b01, 2'b00, i, 1'b0, 1'b0);
      entry(0);
      tick(); tick();
    end
    chk("fill_count", int'(count), 8);
    chk("fill_full", int'(full), 1);

    // Simultaneous entry (gate 0) and exit (gate 1) while full
    push(2'b01, 2'b10, 8, 1'b0, 1'b0);
    drive2(2'b10, 2'b01);
    drive2(2'b11, 2'b11);
    drive2(2'b01, 2'b10);
    drive2(2'b00, 2'b00);
    tick(); tick();
    chk("simul_count", int'(count), 8);
    chk("simul_full", int'(full), 1);
    chk("simul_ovf", int'(ovf), 0);

    // Overflow, then clear
    push(2'b01, 2'b00, 8, 1'b1, 1'b0);
    entry(0);
    tick(); tick();
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(count), 8);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);

    // Drain to empty through gate 1
    for (int i = CAPACITY - 1; i >= 0; i--) begin
      push(2'b00, 2'b10, i, 1'b0, 1'b0);
      exit_pass(1);
      tick(); tick();
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);

    // Underflow with CLR_ERR held at the saturating edge: set wins
    push(2'b00, 2'b10, 0, 1'b0, 1'b1);
    exit_pass(1);
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    chk("unf_set", int'(unf), 1);
    chk("unf_count", int'(count), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("unf_clr", int'(unf), 0);

    // Illegal inputs
    drive(0, 2'b11); chk("ill_idle_11", int'(s[2:0]), 0);
    drive(0, 2'b00);
    drive(0, 2'b01); chk("ill_out1", int'(s[2:0]), 4);
    drive(0, 2'b10); chk("ill_out1_10", int'(s[2:0]), 0);
    chk("ill_no_exit", int'(ext), 0);
    drive(0, 2'b00);
    tick(); tick();

    // Reset mid-IN2 discards the passage
    drive(0, 2'b10);
    drive(0, 2'b11); chk("mid_s0_in2", int'(s[2:0]), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", int'(s), 0);
    sa = '0;
    sb = '0;
    tick();
    rst_n = 1'b1;
    drive(0, 2'b01); chk("mid_after_out1", int'(s[2:0]), 4);
    drive(0, 2'b00); chk("mid_after_idle", int'(s[2:0]), 0);
    chk("mid_no_enter", int'(ent), 0);
    tick(); tick();
    chk("mid_count", int'(count), 0);

    tick(); tick(); tick();
    chk("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
